// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encoding, reset PC default
// and the instruction-alignment mask.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  MISALIGN_MASK    = 2'b11;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch sequencer; hands fetched
// words to decode over valid/ready and squashes stale responses after a redirect.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              misalign_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic              drop_q, drop_d;
    logic              grant;
    logic              bad_target;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            drop_q     <= drop_d;
        end
    end

    // Normal sequencing first; a redirect then overrides whatever it decided.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        drop_d     = drop_q;
        grant      = (state_q == ST_FETCH) && imem_gnt_i;
        bad_target = (redirect_pc_i[1:0] & MISALIGN_MASK) != 2'b00;

        case (state_q)
            ST_FETCH: begin
                if (grant) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready_i) begin
                    pc_d    = pc_plus4_i;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
        endcase

        if (redirect_i && state_q != ST_HALT) begin
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            valid_d   = 1'b0;
            if (bad_target) begin
                misalign_d = 1'b1;
                pc_d       = pc_q;
                drop_d     = drop_q;
                state_d    = ST_HALT;
            end else begin
                pc_d = redirect_pc_i;
                case (state_q)
                    ST_FETCH: begin
                        drop_d  = grant;
                        state_d = grant ? ST_WAIT : ST_FETCH;
                    end
                    ST_WAIT: begin
                        drop_d  = !imem_rvalid_i;
                        state_d = imem_rvalid_i ? ST_FETCH : ST_WAIT;
                    end
                    default: begin
                        drop_d  = drop_q;
                        state_d = ST_FETCH;
                    end
                endcase
            end
        end
    end

    assign imem_req_o   = (state_q == ST_FETCH) && !rst_i;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a directed cycle table, hand-written wrap/reset sequences,
// then random traffic checked against a program-order model of fetch and decode.
module tb_fetch_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_plus4_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_plus4_i    (pc_plus4_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o)
    );

    // Stands in for the parent's PC+4 adder.
    assign pc_plus4_i = pc_o + 32'd4;

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vec [26];

    localparam logic [31:0] A0 = 32'h1111_0001;
    localparam logic [31:0] A1 = 32'h1111_0002;
    localparam logic [31:0] A2 = 32'h1111_0003;
    localparam logic [31:0] A3 = 32'h1111_0004;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic apply_stimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                                  input logic gnt, input logic rv, input logic [31:0] rdata,
                                  input logic rdy);
        @(negedge clk_i);
        rst_i         = rst;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdata;
        inst_ready_i  = rdy;
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] exp_pc;
    logic        pending;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          accepted;
    logic        r_redir, r_gnt, r_rv, r_rdy;
    logic [31:0] r_pc, r_rdata;

    initial begin
        // rst,redir,rpc,gnt,rv,rdata,rdy | req,addr,valid,inst,ipc,pc,mis
        vec[0]  = '{1,0,0,0,0,0,0,                  0,0,0,0,0,0,0};
        vec[1]  = '{0,0,0,1,0,0,0,                  1,0,0,0,0,0,0};
        vec[2]  = '{0,0,0,1,1,A0,0,                 0,0,0,0,0,0,0};
        vec[3]  = '{0,0,0,0,0,0,1,                  0,0,1,A0,0,0,0};
        vec[4]  = '{0,0,0,1,0,0,0,                  1,4,0,A0,0,4,0};
        vec[5]  = '{0,0,0,0,1,A1,0,                 0,4,0,A0,0,4,0};
        vec[6]  = '{0,0,0,0,0,0,1,                  0,4,1,A1,4,4,0};
        vec[7]  = '{0,0,0,1,0,0,0,                  1,8,0,A1,4,8,0};
        vec[8]  = '{0,0,0,0,1,A2,0,                 0,8,0,A1,4,8,0};
        for (int i = 9; i <= 13; i++)
            vec[i] = '{0,0,0,1,1,32'h5555_5555,0,   0,8,1,A2,8,8,0};
        vec[14] = '{0,1,32'h200,0,0,0,1,            0,8,1,A2,8,8,0};
        vec[15] = '{0,0,0,1,0,0,0,                  1,32'h200,0,A2,8,32'h200,0};
        vec[16] = '{0,1,32'h100,0,0,0,0,            0,32'h200,0,A2,8,32'h200,0};
        vec[17] = '{0,0,0,0,1,32'hDEAD,0,           0,32'h100,0,A2,8,32'h100,0};
        vec[18] = '{0,0,0,1,0,0,0,                  1,32'h100,0,A2,8,32'h100,0};
        vec[19] = '{0,0,0,0,1,A3,0,                 0,32'h100,0,A2,8,32'h100,0};
        vec[20] = '{0,0,0,0,0,0,1,                  0,32'h100,1,A3,32'h100,32'h100,0};
        vec[21] = '{0,1,32'h102,0,0,0,0,            1,32'h104,0,A3,32'h100,32'h104,0};
        vec[22] = '{0,0,0,1,0,0,0,                  0,32'h104,0,A3,32'h100,32'h104,1};
        vec[23] = '{0,1,32'h300,1,1,32'hBEEF,1,     0,32'h104,0,A3,32'h100,32'h104,1};
        vec[24] = '{1,0,0,0,0,0,0,                  0,32'h104,0,A3,32'h100,32'h104,1};
        vec[25] = '{0,0,0,0,0,0,0,                  1,0,0,0,0,0,0};

        // Outputs in each row reflect the rows before it; inputs act at the next edge.
        for (int i = 0; i < 26; i++) begin
            apply_stimulus(vec[i].rst, vec[i].redir, vec[i].rpc, vec[i].gnt,
                           vec[i].rv, vec[i].rdata, vec[i].rdy);
            check_output($sformatf("row%0d req", i),   32'(imem_req_o),   32'(vec[i].e_req));
            check_output($sformatf("row%0d addr", i),  imem_addr_o,       vec[i].e_addr);
            check_output($sformatf("row%0d valid", i), 32'(inst_valid_o), 32'(vec[i].e_valid));
            check_output($sformatf("row%0d inst", i),  inst_o,            vec[i].e_inst);
            check_output($sformatf("row%0d ipc", i),   inst_pc_o,         vec[i].e_ipc);
            check_output($sformatf("row%0d pc", i),    pc_o,              vec[i].e_pc);
            check_output($sformatf("row%0d mis", i),   32'(misalign_o),   32'(vec[i].e_mis));
        end

        // PC wraps from the top of the address space to zero.
        apply_stimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        check_output("wrap req_addr", imem_addr_o, 32'hFFFF_FFFC);
        apply_stimulus(0, 0, 0, 0, 1, 32'h7777_7777, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("wrap inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        check_output("wrap inst", inst_o, 32'h7777_7777);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("wrap pc", pc_o, 32'h0000_0000);
        check_output("wrap req", 32'(imem_req_o), 32'd1);

        // Reset while waiting for a response; the late response must be ignored.
        apply_stimulus(0, 1, 32'h40, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        check_output("rstwait pc_before", pc_o, 32'h40);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        check_output("rstwait req_in_reset", 32'(imem_req_o), 32'd0);
        apply_stimulus(0, 0, 0, 0, 1, 32'h9999_9999, 0);
        check_output("rstwait pc", pc_o, 32'h0);
        check_output("rstwait req", 32'(imem_req_o), 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("rstwait late_valid", 32'(inst_valid_o), 32'd0);
        check_output("rstwait late_inst", inst_o, 32'h0);
        check_output("rstwait still_fetch", 32'(imem_req_o), 32'd1);

        // Random traffic: the model tracks only the program-order PC stream.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        exp_pc   = 32'h0;
        pending  = 1'b0;
        pend_addr = '0;
        pend_cnt = 0;
        accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hC);
            r_gnt   = $urandom_range(0, 1) == 1;
            r_rv    = pending && (pend_cnt == 0);
            r_rdata = r_rv ? mem_word(pend_addr) : $urandom;
            r_rdy   = $urandom_range(0, 9) < 7;
            apply_stimulus(0, r_redir, r_pc, r_gnt, r_rv, r_rdata, r_rdy);

            if (imem_req_o && r_gnt) begin
                check_output("rand one_outstanding", 32'(pending), 32'd0);
                check_output("rand fetch_addr", imem_addr_o, exp_pc);
            end
            if (inst_valid_o && r_rdy && !r_redir) begin
                check_output("rand inst_pc", inst_pc_o, exp_pc);
                check_output("rand inst", inst_o, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (r_redir) exp_pc = r_pc;

            if (r_rv) pending = 1'b0;
            else if (pending) pend_cnt--;
            if (imem_req_o && r_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr_o;
                pend_cnt  = $urandom_range(0, 2);
            end
        end
        check_output("rand progress", 32'(accepted > 100), 32'd1);
        check_output("rand misalign", 32'(misalign_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
